// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier front-end: operand and
// product widths, the controller state encoding and the FIFO entry packing.
package mul_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;
   localparam int ENTRY_W = 2 * OP_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      HOLD  = 3'd4
   } state_t;

   // Multiplicand sits in the upper half of a FIFO entry, multiplier in the lower.
   function automatic logic [ENTRY_W-1:0] packPair(input logic [OP_W-1:0] a,
                                                   input logic [OP_W-1:0] b);
      return {a, b};
   endfunction

endpackage

// File: rtl/op_fifo.sv
// Operand-pair FIFO with show-ahead head output and a registered ready flag
// that stays low while reset is asserted.
module op_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] pushData,
   output logic [7:0] popData,
   output logic       full,
   output logic       empty,
   output logic       ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   countNext;
   logic             doPush;
   logic             doPop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = mem[rdPtr];

   // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      countNext = count;
      if (doPush && !doPop) begin
         countNext = count + 1'b1;
      end else if (!doPush && doPop) begin
         countNext = count - 1'b1;
      end
   end

   // Pointers are exactly log2(depth) bits wide, so incrementing wraps them modulo the depth.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         ready <= 1'b0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         count <= countNext;
         ready <= (countNext != DEPTH_C);
      end
   end

   // Storage array needs no reset: occupancy decides which entries are meaningful.
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

endmodule

// File: rtl/mul_seq.sv
// Sequencer that queues signed operand pairs, drives an external multiplier
// stage with a start pulse, waits for it to settle and hands back the product.
module mul_seq
   import mul_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              in_ready,
   output logic [OP_W-1:0]   mul_multiplicand,
   output logic [OP_W-1:0]   mul_multiplier,
   output logic              mul_start,
   input  logic [PROD_W-1:0] mul_product,
   input  logic              mul_busy,
   output logic              res_valid,
   output logic [PROD_W-1:0] res_product,
   input  logic              res_ready
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t               state;
   state_t               stateNext;
   logic [3:0]           waitCnt;
   logic                 fifoPush;
   logic                 fifoPop;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [ENTRY_W-1:0]   fifoHead;
   logic                 leaveWait;

   assign fifoPush  = in_valid && in_ready && !fifoFull;
   assign leaveWait = (state == WAIT) && (waitCnt == '0) && !mul_busy;

   op_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (fifoPush),
      .pop     (fifoPop),
      .pushData(packPair(in_a, in_b)),
      .popData (fifoHead),
      .full    (fifoFull),
      .empty   (fifoEmpty),
      .ready   (in_ready)
   );

   // Next-state logic; the FIFO head is popped on whichever edge enters LOAD.
   always_comb begin
      stateNext = state;
      fifoPop   = 1'b0;
      mul_start = 1'b0;
      case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               stateNext = LOAD;
               fifoPop   = 1'b1;
            end
         end
         LOAD: begin
            stateNext = START;
         end
         START: begin
            mul_start = 1'b1;
            stateNext = WAIT;
         end
         WAIT: begin
            if (leaveWait) begin
               stateNext = HOLD;
            end
         end
         HOLD: begin
            if (res_ready) begin
               if (!fifoEmpty) begin
                  stateNext = LOAD;
                  fifoPop   = 1'b1;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State register; reset abandons whatever pair was in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Operands are captured at the pop and held untouched until the next pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mul_multiplicand <= '0;
         mul_multiplier   <= '0;
      end else if (fifoPop) begin
         mul_multiplicand <= fifoHead[ENTRY_W-1:OP_W];
         mul_multiplier   <= fifoHead[OP_W-1:0];
      end
   end

   // Settle counter: loaded while the start pulse is out, counts down to zero in WAIT.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         waitCnt <= '0;
      end else if (state == START) begin
         waitCnt <= WAIT_INIT;
      end else if ((state == WAIT) && (waitCnt != '0)) begin
         waitCnt <= waitCnt - 1'b1;
      end
   end

   // Result register: product captured raw when WAIT ends, held until accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         res_valid   <= 1'b0;
         res_product <= '0;
      end else if (leaveWait) begin
         res_valid   <= 1'b1;
         res_product <= mul_product;
      end else if ((state == HOLD) && res_ready) begin
         res_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: directed operand pairs push their expected
// product into a queue, a negedge monitor pops and compares on each handshake.
module tb_mul_seq;

   localparam int DEPTH = 4;
   localparam int WAITC = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_a = '0;
   logic [3:0] in_b = '0;
   logic       in_ready;
   logic [3:0] mul_multiplicand;
   logic [3:0] mul_multiplier;
   logic       mul_start;
   logic [7:0] mul_product;
   logic       mul_busy = 1'b0;
   logic       res_valid;
   logic [7:0] res_product;
   logic       res_ready = 1'b1;

   logic signed [7:0] mulProductReg = '0;
   logic [7:0]        expQ[$];
   int                checkCount = 0;
   int                errorCount = 0;
   int                cycleCount = 0;
   int                startCount = 0;
   int                acceptCycle = 0;
   int                riseCycle = -1;
   logic              prevValid = 1'b0;
   logic              prevReady = 1'b0;
   logic [7:0]        prevProduct = '0;

   mul_seq #(
      .FIFO_DEPTH (DEPTH),
      .WAIT_CYCLES(WAITC)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .in_valid        (in_valid),
      .in_a            (in_a),
      .in_b            (in_b),
      .in_ready        (in_ready),
      .mul_multiplicand(mul_multiplicand),
      .mul_multiplier  (mul_multiplier),
      .mul_start       (mul_start),
      .mul_product     (mul_product),
      .mul_busy        (mul_busy),
      .res_valid       (res_valid),
      .res_product     (res_product),
      .res_ready       (res_ready)
   );

   always #5 clock = ~clock;

   // External multiplier stage: product only updates on the start pulse.
   always @(posedge clock) begin
      if (mul_start) begin
         mulProductReg <= $signed(mul_multiplicand) * $signed(mul_multiplier);
      end
   end
   assign mul_product = mulProductReg;

   // Edge and start-pulse counters used for latency and pulse checks.
   always @(posedge clock) begin
      cycleCount <= cycleCount + 1;
      if (mul_start) begin
         startCount <= startCount + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, actual, expected, cycleCount);
      end
   endtask

   task automatic failNow(input string name);
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s: bound expired at cycle %0d", name, cycleCount);
   endtask

   // Monitor: compares each accepted result against the scoreboard head.
   always @(negedge clock) begin
      if (!reset_n) begin
         prevValid = 1'b0;
         prevReady = 1'b0;
      end else begin
         if (res_valid && !prevValid) begin
            riseCycle = cycleCount;
         end
         if (res_valid && prevValid && !prevReady) begin
            checkOutput("hold_stable", {24'd0, res_product}, {24'd0, prevProduct});
         end
         if (res_valid && res_ready) begin
            if (expQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL unexpected_result: got %0h, expected none", res_product);
            end else begin
               checkOutput("result", {24'd0, res_product}, {24'd0, expQ.pop_front()});
            end
         end
         prevValid   = res_valid;
         prevReady   = res_ready;
         prevProduct = res_product;
      end
   end

   // Offer one pair and wait (bounded) for it to be accepted.
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
      bit ok = 0;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         failNow("push_timeout");
         in_valid = 1'b0;
         return;
      end
      @(posedge clock);
      expQ.push_back(exp);
      #1;
      acceptCycle = cycleCount;
      in_valid    = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clock);
         #1;
         if (expQ.size() == 0 && !res_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         failNow("drain_timeout");
         expQ.delete();
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      checkOutput({tag, "_mul_start"}, {31'd0, mul_start}, 32'd0);
      checkOutput({tag, "_operands"}, {24'd0, mul_multiplicand, mul_multiplier}, 32'd0);
      checkOutput({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
      checkOutput({tag, "_res_product"}, {24'd0, res_product}, 32'd0);
   endtask

   initial begin
      int s0;
      int releaseCycle;
      bit ok;
      bit sawValid;

      // Power-on reset
      #1 reset_n = 1'b0;
      #1 checkResetOutputs("por");
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1 checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Single pair, latency and one start pulse
      s0 = startCount;
      riseCycle = -1;
      applyStimulus(4'd3, 4'd5, 8'h0F);
      drain();
      checkOutput("latency", riseCycle - acceptCycle, WAITC + 4);
      checkOutput("start_pulses", startCount - s0, 1);

      // Signed corner pairs, in order
      applyStimulus(4'h8, 4'h8, 8'h40);
      applyStimulus(4'h7, 4'hF, 8'hF9);
      applyStimulus(4'h8, 4'h7, 8'hC8);
      drain();

      // Back-pressure: one pair in HOLD, four queued, FIFO full
      res_ready = 1'b0;
      applyStimulus(4'd1, 4'd2, 8'h02);
      applyStimulus(4'd2, 4'd3, 8'h06);
      applyStimulus(4'hF, 4'hF, 8'h01);
      applyStimulus(4'hE, 4'd3, 8'hFA);
      applyStimulus(4'd4, 4'hD, 8'hF4);
      repeat (6) @(posedge clock);
      #1;
      checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("full_res_valid", {31'd0, res_valid}, 32'd1);
      res_ready = 1'b1;
      drain();

      // mul_busy stall during WAIT
      s0 = startCount;
      applyStimulus(4'd6, 4'hE, 8'hF4);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (mul_start) begin
            ok = 1;
            break;
         end
      end
      if (!ok) failNow("start_timeout");
      mul_busy = 1'b1;
      sawValid = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (res_valid) sawValid = 1;
      end
      checkOutput("stall_no_result", {31'd0, sawValid}, 32'd0);
      checkOutput("stall_start_pulses", startCount - s0, 1);
      releaseCycle = cycleCount;
      mul_busy = 1'b0;
      drain();
      checkOutput("stall_release_latency", riseCycle - releaseCycle, 1);

      // Simultaneous push and pop at count 3
      res_ready = 1'b0;
      applyStimulus(4'd1, 4'd1, 8'h01);
      applyStimulus(4'd2, 4'd2, 8'h04);
      applyStimulus(4'd3, 4'd3, 8'h09);
      applyStimulus(4'hD, 4'd3, 8'hF7);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clock);
         #1;
         if (res_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) failNow("hold_timeout");
      res_ready = 1'b1;
      in_a      = 4'd5;
      in_b      = 4'd5;
      in_valid  = 1'b1;
      @(posedge clock);
      expQ.push_back(8'h19);
      #1;
      in_valid  = 1'b0;
      res_ready = 1'b0;
      checkOutput("pushpop_count3_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(4'd6, 4'd6, 8'h24);
      checkOutput("pushpop_now_full", {31'd0, in_ready}, 32'd0);
      res_ready = 1'b1;
      drain();

      // Reset in WAIT with two pairs queued
      mul_busy = 1'b1;
      applyStimulus(4'd2, 4'd5, 8'h0A);
      applyStimulus(4'd3, 4'hC, 8'hF4);
      applyStimulus(4'd1, 4'h8, 8'hF8);
      repeat (4) @(posedge clock);
      #2 reset_n = 1'b0;
      #1 checkResetOutputs("midrst");
      expQ.delete();
      mul_busy = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1 checkOutput("ready_after_midrst", {31'd0, in_ready}, 32'd1);
      sawValid = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (res_valid) sawValid = 1;
      end
      checkOutput("no_stale_result", {31'd0, sawValid}, 32'd0);
      applyStimulus(4'h9, 4'd3, 8'hEB);
      drain();

      checkOutput("scoreboard_empty", expQ.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Global watchdog in case a bounded loop is somehow bypassed.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

endmodule
